uart_note_loader: RTL and testbench

- UART receive front end for the song store.
- Deserialises 8N1 bytes from the board's UART_RX pin and packs byte pairs into 12-bit note words.
- Issues single-cycle write strobes with an auto-incrementing address into the register-file song memory.
- Exposes the last received byte for the seven-segment "writing" mode display. Sits directly upstream of regfile (write port) and model_ctl (read/addr/wen display inputs).

---
 rtl/uart_note_loader_pkg.sv | 22 ++
 rtl/uart_rx_byte.sv | 95 +++++++++
 rtl/uart_note_loader.sv | 91 +++++++++
 tb/tb_uart_note_loader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_note_loader_pkg.sv
// Shared constants, state encodings and the bit-period helper for the UART note loader.
package uart_note_loader_pkg;

  localparam logic [7:0] CMD_START_SONG = 8'hFF;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic {
    PK_WAIT_HI,
    PK_WAIT_LO
  } pk_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, stop-bit check.
module uart_rx_byte
  import uart_note_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_v,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta;
  logic             rxs;
  rx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;

  // Idle-high synchroniser so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      byte_v    <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_v    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rxs) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        // Re-check the start bit at its centre to reject short glitches.
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            if (idx == 3'd7) state <= RX_STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rxs) begin
              byte_v  <= 1'b1;
              rx_byte <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_note_loader.sv
// UART front end for the song store: packs byte pairs into 12-bit notes and writes them
// to sequential addresses, with a 0xFF start-of-song command and an inter-byte timeout.
module uart_note_loader
  import uart_note_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [7:0]        read,
  output logic [11:0]       data_c,
  output logic              wen_c,
  output logic [ADDR_W-1:0] addr_c,
  output logic              frame_err,
  output logic              full
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned TO_CYC       = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W         = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic            byte_v;
  pk_state_e       pk_state;
  logic [3:0]      hi;
  logic [TO_W-1:0] to_cnt;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .byte_v   (byte_v),
    .rx_byte  (read),
    .frame_err(frame_err)
  );

  // read is loaded on the same edge byte_v rises, so it already holds the new byte here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_state <= PK_WAIT_HI;
      hi       <= '0;
      to_cnt   <= '0;
      data_c   <= '0;
      wen_c    <= 1'b0;
      addr_c   <= '0;
      full     <= 1'b0;
    end else begin
      wen_c <= 1'b0;
      if (wen_c) begin
        if (addr_c == ADDR_MAX) full   <= 1'b1;
        else                    addr_c <= addr_c + ADDR_W'(1);
      end
      case (pk_state)
        PK_WAIT_HI: begin
          if (byte_v) begin
            if (read == CMD_START_SONG) begin
              addr_c <= '0;
              full   <= 1'b0;
            end else begin
              hi       <= read[3:0];
              to_cnt   <= '0;
              pk_state <= PK_WAIT_LO;
            end
          end
        end
        PK_WAIT_LO: begin
          if (byte_v) begin
            pk_state <= PK_WAIT_HI;
            if (!full) begin
              data_c <= {hi, read};
              wen_c  <= 1'b1;
            end
          end else if (frame_err || to_cnt == TO_LAST) begin
            pk_state <= PK_WAIT_HI;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: pk_state <= PK_WAIT_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_note_loader.sv
// Directed bench for uart_note_loader: 16 clk/bit, a 16-bit-address and a 2-bit-address instance on one rx line.
module tb_uart_note_loader;
  import uart_note_loader_pkg::*;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned CPB    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;

  logic [7:0]  read1, read2;
  logic [11:0] data1, data2;
  logic        wen1, wen2, fe1, fe2, full1, full2;
  logic [15:0] addr1;
  logic [1:0]  addr2;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int bv_cnt = 0;
  logic [15:0] q_addr1[$];
  logic [11:0] q_data1[$];
  logic [15:0] q_addr2[$];
  logic [11:0] q_data2[$];

  uart_note_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(16), .TIMEOUT_BITS(20)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .read(read1), .data_c(data1), .wen_c(wen1),
    .addr_c(addr1), .frame_err(fe1), .full(full1)
  );

  uart_note_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(2), .TIMEOUT_BITS(20)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .read(read2), .data_c(data2), .wen_c(wen2),
    .addr_c(addr2), .frame_err(fe2), .full(full2)
  );

  always #5 clk = ~clk;

  // Log every write strobe and pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wen1) begin q_addr1.push_back(addr1); q_data1.push_back(data1); end
    if (wen2) begin q_addr2.push_back({14'b0, addr2}); q_data2.push_back(data2); end
    if (fe1) fe_cnt++;
    if (dut1.u_rx.byte_v) bv_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_logs();
    q_addr1.delete(); q_data1.delete(); q_addr2.delete(); q_data2.delete();
    fe_cnt = 0;
    bv_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (read1 !== 8'h00)   begin n_bad++; $display("FAIL reset_read: got %h want 00", read1); end
    n_cmp++; if (data1 !== 12'h000) begin n_bad++; $display("FAIL reset_data: got %h want 000", data1); end
    n_cmp++; if (wen1 !== 1'b0)     begin n_bad++; $display("FAIL reset_wen: got %b want 0", wen1); end
    n_cmp++; if (addr1 !== 16'h0)   begin n_bad++; $display("FAIL reset_addr: got %h want 0000", addr1); end
    n_cmp++; if (fe1 !== 1'b0)      begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", fe1); end
    n_cmp++; if (full1 !== 1'b0)    begin n_bad++; $display("FAIL reset_full: got %b want 0", full1); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clear_logs();
  endtask

  task automatic test_basic();
    clear_logs();
    send_byte(8'h03, 1'b1);
    send_byte(8'hA5, 1'b1);
    n_cmp++; if (q_data1.size() != 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", q_data1.size()); end
    n_cmp++; if (q_data1.size() < 1 || q_data1[0] !== 12'h3A5) begin n_bad++; $display("FAIL basic_data: got %p want 3a5", q_data1); end
    n_cmp++; if (q_addr1.size() < 1 || q_addr1[0] !== 16'h0) begin n_bad++; $display("FAIL basic_addr: got %p want 0", q_addr1); end
    n_cmp++; if (read1 !== 8'hA5) begin n_bad++; $display("FAIL basic_read: got %h want a5", read1); end
    n_cmp++; if (addr1 !== 16'h1) begin n_bad++; $display("FAIL basic_addr_after: got %h want 0001", addr1); end
  endtask

  task automatic test_start_cmd();
    clear_logs();
    send_byte(8'hFF, 1'b1);
    n_cmp++; if (addr1 !== 16'h0 || q_data1.size() != 0) begin n_bad++; $display("FAIL cmd_reset_addr: got addr %h writes %0d want 0/0", addr1, q_data1.size()); end
    send_byte(8'h01, 1'b1); send_byte(8'h23, 1'b1);
    send_byte(8'h0F, 1'b1); send_byte(8'hFF, 1'b1);
    n_cmp++; if (q_data1.size() != 2) begin n_bad++; $display("FAIL cmd_count: got %0d want 2", q_data1.size()); end
    n_cmp++; if (q_data1.size() < 2 || q_data1[0] !== 12'h123 || q_addr1[0] !== 16'h0) begin n_bad++; $display("FAIL cmd_write0: got %p @ %p want 123 @ 0", q_data1, q_addr1); end
    n_cmp++; if (q_data1.size() < 2 || q_data1[1] !== 12'hFFF || q_addr1[1] !== 16'h1) begin n_bad++; $display("FAIL cmd_write1: got %p @ %p want fff @ 1", q_data1, q_addr1); end
    n_cmp++; if (addr1 !== 16'h2) begin n_bad++; $display("FAIL cmd_addr_after: got %h want 0002", addr1); end
  endtask

  task automatic test_frame_err();
    clear_logs();
    send_byte(8'h02, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (CPB * 3) @(negedge clk);
    n_cmp++; if (fe_cnt != 1) begin n_bad++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt); end
    n_cmp++; if (q_data1.size() != 0) begin n_bad++; $display("FAIL ferr_no_write: got %0d writes want 0", q_data1.size()); end
    n_cmp++; if (read1 !== 8'h02) begin n_bad++; $display("FAIL ferr_read: got %h want 02", read1); end
    send_byte(8'h04, 1'b1); send_byte(8'h56, 1'b1);
    n_cmp++; if (q_data1.size() != 1 || q_data1[0] !== 12'h456 || q_addr1[0] !== 16'h2) begin n_bad++; $display("FAIL ferr_next_pair: got %p @ %p want 456 @ 2", q_data1, q_addr1); end
  endtask

  task automatic test_timeout();
    clear_logs();
    send_byte(8'h07, 1'b1);
    repeat (21 * CPB) @(negedge clk);
    send_byte(8'h08, 1'b1); send_byte(8'h9A, 1'b1);
    n_cmp++; if (q_data1.size() != 1) begin n_bad++; $display("FAIL timeout_count: got %0d want 1", q_data1.size()); end
    n_cmp++; if (q_data1.size() < 1 || q_data1[0] !== 12'h89A || q_addr1[0] !== 16'h3) begin n_bad++; $display("FAIL timeout_write: got %p @ %p want 89a @ 3", q_data1, q_addr1); end
  endtask

  task automatic test_glitch();
    clear_logs();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (bv_cnt != 0) begin n_bad++; $display("FAIL glitch_byte_v: got %0d want 0", bv_cnt); end
    n_cmp++; if (fe_cnt != 0) begin n_bad++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt); end
    n_cmp++; if (dut1.u_rx.state !== RX_IDLE) begin n_bad++; $display("FAIL glitch_idle: got %0d want %0d", dut1.u_rx.state, RX_IDLE); end
    n_cmp++; if (read1 !== 8'h9A) begin n_bad++; $display("FAIL glitch_read: got %h want 9a", read1); end
    send_byte(8'h01, 1'b1); send_byte(8'h11, 1'b1);
    n_cmp++; if (q_data1.size() != 1 || q_data1[0] !== 12'h111 || q_addr1[0] !== 16'h4) begin n_bad++; $display("FAIL glitch_after: got %p @ %p want 111 @ 4", q_data1, q_addr1); end
  endtask

  task automatic test_full();
    logic [11:0] exp_d [4];
    exp_d[0] = 12'h111; exp_d[1] = 12'h222; exp_d[2] = 12'h333; exp_d[3] = 12'h444;
    send_byte(8'hFF, 1'b1);
    clear_logs();
    n_cmp++; if (addr2 !== 2'd0 || full2 !== 1'b0) begin n_bad++; $display("FAIL full_cmd: got addr %0d full %b want 0/0", addr2, full2); end
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(i + 1), 1'b1);
      send_byte(8'(8'h11 * (i + 1)), 1'b1);
    end
    n_cmp++; if (full2 !== 1'b1 || addr2 !== 2'd3) begin n_bad++; $display("FAIL full_set: got full %b addr %0d want 1/3", full2, addr2); end
    send_byte(8'h05, 1'b1); send_byte(8'h55, 1'b1);
    n_cmp++; if (q_data2.size() != 4) begin n_bad++; $display("FAIL full_count: got %0d want 4", q_data2.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (q_data2.size() != 4 || q_data2[i] !== exp_d[i] || q_addr2[i] !== 16'(i)) begin
        n_bad++; $display("FAIL full_write%0d: got %p @ %p want %h @ %0d", i, q_data2, q_addr2, exp_d[i], i);
      end
    end
    send_byte(8'hFF, 1'b1);
    n_cmp++; if (full2 !== 1'b0 || addr2 !== 2'd0) begin n_bad++; $display("FAIL full_clear: got full %b addr %0d want 0/0", full2, addr2); end
    q_addr2.delete(); q_data2.delete();
    send_byte(8'h06, 1'b1); send_byte(8'h66, 1'b1);
    n_cmp++; if (q_data2.size() != 1 || q_data2[0] !== 12'h666 || q_addr2[0] !== 16'h0) begin n_bad++; $display("FAIL full_restart: got %p @ %p want 666 @ 0", q_data2, q_addr2); end
    n_cmp++; if (addr2 !== 2'd1) begin n_bad++; $display("FAIL full_restart_addr: got %0d want 1", addr2); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_start_cmd();
    test_frame_err();
    test_timeout();
    test_glitch();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
